gate_not_arbiter: RTL
=====================

Name: gate_not_arbiter

Overview:
Round-robin arbiter that shares one N-bit bitwise-inverter datapath (F = ~A) between R requesters. Each requester offers an operand with a valid/ready handshake. The block grants one requester at a time and registers the inverted result with the winner's ID. It presents the result on a valid/ready output port. It sits in front of the shared inverter datapath, as its sequencer and access controller.

Parameters:
N, 4, operand/result width in bits (N >= 1)
R, 4, number of requesters (R >= 1); ID width IW = (R > 1) ? $clog2(R) : 1

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  R  bit i: requester i offers an operand
req_data  input  R*N  operand of requester i in bits [i*N +: N]
req_ready  output  R  bit i: requester i's operand is accepted this cycle (one-hot or zero)
res_valid  output  1  result register holds a valid result
res_data  output  N  registered result, bitwise NOT of the granted operand
res_id  output  IW  index of the requester that produced res_data
res_ready  input  1  downstream accepts the result
busy  output  1  high while a result is held (state HOLD)

Behaviour:
- Reset, async assert, sync release via clk:
  - state = IDLE, res_valid = 0, res_data = 0, res_id = 0, busy = 0, req_ready = 0.
  - Round-robin pointer last = R-1, so requester 0 has highest priority first.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - Winner w = first i with req_valid[i], searching from (last+1) mod R upward with wrap-around.
  - req_ready[w] = 1 combinationally in the same cycle; all other bits are 0. If no req_valid bit is set, req_ready = 0 and the state stays IDLE.
  - On the accept edge: res_data <= ~req_data[w*N +: N], res_id <= w, res_valid <= 1, last <= w, state -> HOLD.
- HOLD:
  - req_ready = 0; res_valid, res_data and res_id are held stable. busy = 1.
  - When res_valid && res_ready: res_valid <= 0, state -> IDLE. res_data and res_id keep their last value.
- Latency: result is visible one cycle after acceptance.
- Throughput: at most one result every 2 cycles. There is no accept during HOLD, even if res_ready is high.
- Requester protocol: hold req_valid and operand stable until ready. Arbitration is re-evaluated every IDLE cycle, so a requester that drops valid before being granted simply loses its turn. Grants are never locked.
- Fairness: with all R requesters continuously valid, grants follow the order 0, 1, ..., R-1, 0, ...
- Pointer wrap: after a grant to R-1, the search starts at 0.
- R = 1: requester 0 always wins; res_id is always 0.
- res_ready high while res_valid = 0 has no effect.
- Reset asserted mid-HOLD: the pending result is discarded and all outputs take their reset values immediately.
- Width rule: result is exactly N bits. No extension or truncation.

Optional Feature:
Macro GATE_NOT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index valid requester always wins, and the last pointer is neither implemented nor updated.
- Undefined (default): round-robin as described above.
- All ports, latency and handshake timing are identical in both builds.

Test Plan:
- Reset then idle. Hold rst_n = 0 for 2 cycles, then release with all req_valid = 0 for 5 cycles. Expect res_valid = 0, res_data = 0, busy = 0 and req_ready = 0 throughout.
- Single request. req_valid = 4'b0100, req_data[2] = 4'b1010, res_ready = 1. Expect req_ready = 4'b0100 for one cycle. Next cycle expect res_valid = 1, res_data = 4'b0101, res_id = 2. res_valid drops the cycle after.
- Round-robin under full load. All 4 requesters valid with operands 4'b0000, 4'b1100, 4'b1111 and 4'b0011, res_ready = 1.
  - Expect res_id sequence 0, 1, 2, 3, 0.
  - Expect res_data 4'b1111, 4'b0011, 4'b0000, 4'b1100, 4'b1111.
  - Expect one result every 2 cycles.
- Backpressure. Request 1 with 4'b1010 and res_ready = 0 for 4 cycles. Expect res_valid = 1, res_data = 4'b0101 and res_id = 1 stable, busy = 1, and req_ready = 0 even though req_valid[0] = 1. Raise res_ready: the next grant goes to requester 0 one cycle after the output handshake.
- Reset mid-operation. Assert rst_n = 0 asynchronously while in HOLD with res_data = 4'b0011. Expect res_valid = 0 and res_data = 0 immediately without a clock edge. After release with all requesters valid, the first grant goes to requester 0.
- Fixed-priority build (GATE_NOT_ARB_FIXED_PRIO_EN defined). Requesters 0 and 3 continuously valid. Expect res_id = 0 on every result and requester 3 never granted.

Source files
------------

// File: rtl/gate_not_arbiter.sv
// Round-robin arbiter sequencing R requesters onto one shared N-bit inverter (F = ~A).
// Define GATE_NOT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module gate_not_arbiter #(
  parameter  int N  = 4,
  parameter  int R  = 4,
  localparam int IW = (R > 1) ? $clog2(R) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req_valid,
  input  logic [R*N-1:0] req_data,
  output logic [R-1:0]   req_ready,
  output logic           res_valid,
  output logic [N-1:0]   res_data,
  output logic [IW-1:0]  res_id,
  input  logic           res_ready,
  output logic           busy
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e          state_q, state_d;
  logic            res_valid_q, res_valid_d;
  logic [N-1:0]    res_data_q, res_data_d;
  logic [IW-1:0]   res_id_q, res_id_d;
  logic            found;
  logic [IW-1:0]   win;

`ifdef GATE_NOT_ARB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    win   = '0;
    // Descending scan so the lowest valid index is the last one written.
    for (int k = R - 1; k >= 0; k--) begin
      if (req_valid[IW'(k)]) begin
        found = 1'b1;
        win   = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0]   last_q, last_d;
  int              idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < R; k++) begin
      idx = int'(last_q) + 1 + k;
      if (idx >= R) idx = idx - R;
      if (!found && req_valid[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    req_ready   = '0;
`ifndef GATE_NOT_ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          // Gated by rst_n so the grant disappears the instant reset asserts.
          req_ready[win] = rst_n;
          res_data_d     = ~req_data[int'(win)*N +: N];
          res_id_d       = win;
          res_valid_d    = 1'b1;
          state_d        = HOLD;
`ifndef GATE_NOT_ARB_FIXED_PRIO_EN
          last_d         = win;
`endif
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
`ifndef GATE_NOT_ARB_FIXED_PRIO_EN
      last_q      <= IW'(R - 1);
`endif
    end else begin
      state_q     <= state_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
`ifndef GATE_NOT_ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q == HOLD);

endmodule
